// File: rtl/mem_resp_pkg.sv
// Shared constants and FSM state type for the cache-side memory responder.
package mem_resp_pkg;

  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned DEPTH_WORDS_DEF = 32768;
  localparam int unsigned LATENCY_DEF     = 4;
  localparam int unsigned BURST_LEN_DEF   = 8;
  localparam int unsigned LINE_OFS_W      = $clog2(BURST_LEN_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-latency shift register carrying {valid, addr, data, last} from issue to response.
module mem_delay_pipe
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              any_valid
);

  logic [LATENCY-1:0]             vld_q, vld_d;
  logic [LATENCY-1:0]             last_q, last_d;
  logic [LATENCY-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d     = '0;
    last_d    = '0;
    addr_d    = '0;
    data_d    = '0;
    vld_d[0]  = in_valid;
    last_d[0] = in_last;
    addr_d[0] = in_addr;
    data_d[0] = in_data;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
      addr_d[i] = addr_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_last  = last_q[LATENCY-1];
  assign out_addr  = addr_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/mem_responder.sv
// Pipelined main-memory responder for the cache miss/fill path.
// Optional line-burst reads are enabled by defining MEM_BURST_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = LATENCY_DEF,
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy
);

  localparam int unsigned OFS_W  = $clog2(BURST_LEN);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned BASE_W = ADDR_W - OFS_W - 1;

  logic [DATA_W-1:0] mem_array [DEPTH_WORDS];

  logic              accept;
  logic              wr_en;
  logic              issue_valid;
  logic              issue_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              burst_active;
  logic              pipe_any_valid;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a[ADDR_W-1:1] % DEPTH_WORDS);
  endfunction

  assign accept = req_valid & req_ready & ~rst;
  assign wr_en  = accept & req_wr;

`ifdef MEM_BURST_EN
  mem_state_e        state_q, state_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              unused_bits;

  assign unused_bits  = req_addr[0];
  assign req_ready    = (state_q == ST_IDLE);
  assign burst_active = (state_q == ST_BURST);

  // Beat 0 issues on the accept edge; the remaining beats follow one per edge
  // from the captured line base, so the offset never leaves the line.
  always_comb begin
    state_d     = state_q;
    ofs_d       = ofs_q;
    base_d      = base_q;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    issue_addr  = '0;
    if (state_q == ST_BURST) begin
      issue_valid = 1'b1;
      issue_addr  = {base_q, ofs_q, 1'b0};
      ofs_d       = ofs_q + 1'b1;
      if (ofs_q == OFS_W'(BURST_LEN - 1)) begin
        issue_last = 1'b1;
        state_d    = ST_IDLE;
      end
    end else if (accept && !req_wr) begin
      issue_valid = 1'b1;
      if (req_burst) begin
        base_d     = req_addr[ADDR_W-1 -: BASE_W];
        issue_addr = {req_addr[ADDR_W-1 -: BASE_W], {(OFS_W + 1){1'b0}}};
        ofs_d      = OFS_W'(1);
        state_d    = ST_BURST;
      end else begin
        issue_addr = {req_addr[ADDR_W-1:1], 1'b0};
        issue_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ofs_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      base_q  <= base_d;
    end
  end
`else
  logic unused_bits;

  assign unused_bits  = ^{req_burst, req_addr[0]};
  assign req_ready    = 1'b1;
  assign burst_active = 1'b0;

  always_comb begin
    issue_valid = accept & ~req_wr;
    issue_last  = 1'b1;
    issue_addr  = {req_addr[ADDR_W-1:1], 1'b0};
  end
`endif

  // Read data is captured at issue, so later writes cannot disturb it.
  assign issue_data = mem_array[word_idx(issue_addr)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[word_idx(req_addr)] <= req_wdata;
    end
  end

  mem_delay_pipe #(
    .LATENCY (LATENCY),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid),
    .in_addr   (issue_addr),
    .in_data   (issue_data),
    .in_last   (issue_last),
    .out_valid (rsp_valid),
    .out_addr  (rsp_addr),
    .out_data  (rsp_rdata),
    .out_last  (rsp_last),
    .any_valid (pipe_any_valid)
  );

  assign busy = burst_active | pipe_any_valid;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level reference model.
module tb_mem_responder;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 4;
  localparam int unsigned BL  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_wr, req_burst;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, rsp_last, busy;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH_WORDS (32768),
    .LATENCY     (LAT),
    .BURST_LEN   (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [int unsigned];
  int unsigned   n = 0;
  int unsigned   burst_end = 0;
  bit            model_rdy = 1'b1;
  bit            burst_en;
  int            errors = 0;
  int            checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [AW-1:0] a);
    return int'(a >> 1);
  endfunction

  // One clock: update the model with what the DUT sees at this edge, then check outputs.
  task automatic step();
    logic [AW-1:0] base;
    logic [AW-1:0] line_mask;
    @(posedge clk);
    n++;
    if (rst) begin
      exp_q.delete();
      burst_end = n;
    end else if (req_valid && model_rdy) begin
      if (req_wr) begin
        mem_m[widx(req_addr)] = req_wdata;
      end else if (burst_en && req_burst) begin
        line_mask = AW'(2 * BL - 1);
        base      = req_addr & ~line_mask;
        for (int unsigned k = 0; k < BL; k++) begin
          exp_q.push_back('{n + k + LAT - 1, base + AW'(2 * k),
                            mem_m[widx(base + AW'(2 * k))], k == BL - 1});
        end
        burst_end = n + BL - 1;
      end else begin
        exp_q.push_back('{n + LAT - 1, req_addr & ~AW'(1), mem_m[widx(req_addr)], 1'b1});
      end
    end
    model_rdy = (n >= burst_end);
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(model_rdy));
    check_eq("busy", 32'(busy), 32'((exp_q.size() > 0) || !model_rdy));
    if (exp_q.size() > 0 && exp_q[0].due == n) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_addr", 32'(rsp_addr), 32'(exp_q[0].addr));
      check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
      check_eq("rsp_last", 32'(rsp_last), 32'(exp_q[0].last));
      void'(exp_q.pop_front());
    end else begin
      check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic bst,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_wr    = wr;
    req_burst = bst;
    req_addr  = a;
    req_wdata = d;
    step();
  endtask

  task automatic idle(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
`ifdef MEM_BURST_EN
    burst_en = 1'b1;
`else
    burst_en = 1'b0;
`endif
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    step();
    step();
    check_eq("reset_rsp_addr", 32'(rsp_addr), 32'd0);
    check_eq("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("reset_rsp_last", 32'(rsp_last), 32'd0);
    rst = 1'b0;

    // Preload the 128-word window used by all later traffic.
    for (int unsigned w = 0; w < 128; w++)
      drive(1'b1, 1'b1, 1'b0, AW'(2 * w), DW'($urandom));
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h000A);
    drive(1'b1, 1'b1, 1'b0, 16'h0002, 16'h000B);
    drive(1'b1, 1'b1, 1'b0, 16'h0004, 16'h000C);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h5555);

    // Write then immediate read of the same word.
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    drive(1'b1, 1'b0, 1'b0, 16'h0010, '0);
    idle(LAT + 2);

    // Back-to-back single reads.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, '0);
    drive(1'b1, 1'b0, 1'b0, 16'h0002, '0);
    drive(1'b1, 1'b0, 1'b0, 16'h0004, '0);
    idle(LAT + 2);

    // Burst with a read held through the not-ready window.
    drive(1'b1, 1'b0, 1'b1, 16'h0046, '0);
    for (int unsigned i = 0; i < BL; i++) drive(1'b1, 1'b0, 1'b0, 16'h0010, '0);
    idle(LAT + BL + 2);

    // Read followed by a write to the same word, then re-read.
    drive(1'b1, 1'b0, 1'b0, 16'h0020, '0);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h6666);
    drive(1'b1, 1'b0, 1'b0, 16'h0020, '0);
    idle(LAT + 2);

    // Reset part-way through a burst.
    drive(1'b1, 1'b0, 1'b1, 16'h0080, '0);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(LAT + BL + 2);

    // Random traffic with occasional resets.
    for (int unsigned i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, AW'($urandom_range(0, 255)), DW'($urandom));
    end
    rst = 1'b0;
    idle(LAT + BL + 4);
    check_eq("drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle, pipelined main-memory responder sitting behind `pipelined_cache_control`. It services the cache side of the memory interface. It accepts single-word reads and writes from the I-cache/D-cache miss logic, and optionally whole-line burst reads. Read data returns in order after a fixed latency, tagged with its byte address, so the cache fill FSM can write each word straight into the line.

## Interface
- `ADDR_W`, 16, byte-address width.
- `DATA_W`, 16, word width.
- `DEPTH_WORDS`, 32768, storage depth in words; word index = `req_addr[ADDR_W-1:1]` mod `DEPTH_WORDS`.
- `LATENCY`, 4, read latency in cycles (legal range 1..8).
- `BURST_LEN`, 8, words per cache line (power of two; 8 = 16-byte block).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request this cycle.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_burst` in 1: line-burst read (only with `MEM_BURST_EN`; ignored otherwise and when `req_wr`=1).
- `req_addr` in `ADDR_W`: byte address; bit 0 ignored.
- `req_wdata` in `DATA_W`: write data.
- `rsp_valid` out 1: read data valid this cycle.
- `rsp_addr` out `ADDR_W`: byte address of returned word, bit 0 = 0.
- `rsp_rdata` out `DATA_W`: read data.
- `rsp_last` out 1: final word of a burst (or any single read).
- `busy` out 1: any read in flight or burst in progress.

## Operation
- Request accepted at rising edge where `req_valid & req_ready`.
- Write: array word updated at accept edge; no response generated; write never stalls (`req_ready` stays high unless a burst is active).
- Single read: array sampled at accept edge; {addr, data, last=1} enters the delay pipe.
- Burst FSM, states IDLE and BURST:
  - IDLE→BURST on accepted read with `req_burst`=1. Beat 0 issues at the accept edge, at address `{req_addr[ADDR_W-1:4], 4'b0}` (line-aligned, critical-word ignored).
  - BURST: one beat issued per edge at word offset k = 1..BURST_LEN-1; offset counter is 3 bits and never crosses the line boundary.
  - BURST→IDLE at the edge issuing beat BURST_LEN-1; that beat carries last=1.
  - `req_ready` = 0 while in BURST.
- Data is captured at issue, so a write accepted after a read to the same word never alters that read's returned data.
- Read-after-write to the same word, back-to-back: the read returns the new data.
- Responses strictly in issue order; pipe holds at most `LATENCY` entries, so back-pressure is unnecessary.
- `busy` = (state==BURST) | any pipe valid bit set.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_addr`=0, `rsp_rdata`=0, `rsp_last`=0, `busy`=0; FSM=IDLE; pipe valid bits cleared. Array contents not reset.
- Reset mid-burst or with reads in flight: all pending beats discarded. No `rsp_valid` in the cycle after reset.
- Read accepted at edge t → `rsp_valid`=1 in the cycle following edge t+LATENCY-1, i.e. LATENCY cycles after acceptance. `LATENCY`=1 means data appears in the cycle immediately after the accept edge.
- Burst accepted at edge t → beat k valid LATENCY+k cycles after acceptance, contiguous, BURST_LEN cycles total. `req_ready` is low for the BURST_LEN-1 cycles following acceptance.
- Outputs all registered; no combinational path from `req_*` to `rsp_*`. `req_ready` depends only on state.

## Configuration
- `MEM_BURST_EN` defined: burst FSM and `req_burst` honoured as above.
- `MEM_BURST_EN` undefined:
  - FSM and offset counter are removed; `req_ready` is tied to 1.
  - `req_burst` is ignored, so every read is single-word with `rsp_last`=1.
  - The cache fill FSM must issue BURST_LEN separate reads.

## Structure
- Package `mem_resp_pkg`:
  - default `ADDR_W`/`DATA_W`/`LATENCY`/`BURST_LEN` constants
  - FSM state enum (IDLE, BURST)
  - `LINE_OFS_W` = log2(BURST_LEN)
- Sub-module `mem_delay_pipe`: LATENCY-deep shift register of {valid, addr, data, last}, cleared by `rst`. The top level holds the array, accept logic and burst FSM.

## Test plan
- Write 0x1234 to 0x0010; read 0x0010 the next cycle → `rsp_valid` exactly 4 cycles after accept, `rsp_rdata`=0x1234, `rsp_addr`=0x0010, `rsp_last`=1.
- Reads to 0x0000, 0x0002, 0x0004 on consecutive cycles (preloaded 0xA, 0xB, 0xC) → three contiguous responses in order, each with its own address.
- Burst read at 0x0046 → 8 beats at 0x0040..0x004E, `rsp_last` only on 0x004E. `req_ready` is low for 7 cycles, and a `req_valid` held during them is accepted only at the next ready cycle.
- Read 0x0020 (old 0x5555), then write 0x0020=0x6666 the next cycle → response 0x5555; a subsequent read returns 0x6666.
- Assert `rst` at beat 3 of a burst → no `rsp_valid` afterwards, `req_ready`=1 and `busy`=0 in the cycle after reset.
- Build without `MEM_BURST_EN` and set `req_burst`=1 on a read to 0x0046 → a single response for 0x0046 only, and `req_ready` never drops.
